img_stream_gen: RTL and testbench

IMG_STREAM_GEN -- requirements
Module: img_stream_gen

---
 rtl/img_stream_pkg.sv | 22 ++
 rtl/img_stream_gen_if.sv | 24 ++
 rtl/img_pattern_calc.sv | 40 ++++
 rtl/img_stream_gen.sv | 180 ++++++++++++++++++
 tb/tb_img_stream_gen.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/img_stream_pkg.sv
// Shared types and constants for the image stream generator.
package img_stream_pkg;

    localparam int unsigned CNT_W = 12;
    localparam int unsigned PIX_W = 8;

    // Frame sequencing phases.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_LINE,
        ST_HBLANK,
        ST_TAIL
    } state_t;

    // Pixel pattern codes, latched once per frame.
    typedef enum logic {
        PAT_RAMP    = 1'b0,
        PAT_CHECKER = 1'b1
    } pattern_t;

endpackage

// File: rtl/img_stream_gen_if.sv
// Pixel stream bundle: frame/line sync, valid and grayscale data.
interface img_stream_gen_if;
    import img_stream_pkg::*;

    logic             post_img_vsync;
    logic             post_img_hsync;
    logic             post_img_valid;
    logic [PIX_W-1:0] post_img_data;

    modport master (
        output post_img_vsync,
        output post_img_hsync,
        output post_img_valid,
        output post_img_data
    );

    modport slave (
        input post_img_vsync,
        input post_img_hsync,
        input post_img_valid,
        input post_img_data
    );

endinterface

// File: rtl/img_pattern_calc.sv
// Registered pixel generator: ramp, plus checkerboard when
// IMG_STREAM_GEN_CHECKER_EN is defined. Inputs are next-cycle coordinates so
// the registered data lines up with the registered valid.
module img_pattern_calc
    import img_stream_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_d,
    input  logic [PIX_W-1:0] x_lo,
    input  logic [PIX_W-1:0] y_lo,
    input  logic [PIX_W-1:0] frame_cnt,
`ifdef IMG_STREAM_GEN_CHECKER_EN
    input  pattern_t         pat,
`endif
    output logic [PIX_W-1:0] data
);

    logic [PIX_W-1:0] pix_c;

    // Pattern selection for the upcoming pixel.
    always_comb begin
        pix_c = x_lo + y_lo + frame_cnt;
`ifdef IMG_STREAM_GEN_CHECKER_EN
        if (pat == PAT_CHECKER) begin
            pix_c = (x_lo[3] ^ y_lo[3]) ? 8'hFF : 8'h00;
        end
`endif
    end

    // Data register; forced to zero outside active pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else begin
            data <= valid_d ? pix_c : '0;
        end
    end

endmodule

// File: rtl/img_stream_gen.sv
// Test-image stream generator: LEAD / LINE / HBLANK / TAIL frame timing with
// registered sync, valid and pixel data. Optional checkerboard pattern is
// compiled in with IMG_STREAM_GEN_CHECKER_EN.
module img_stream_gen
    import img_stream_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned H_BLANK  = 160,
    parameter int unsigned V_LEAD   = 16,
    parameter int unsigned V_TAIL   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 continuous,
    input  logic                 pattern_sel,
    output logic                 busy,
    output logic                 frame_done,
    output logic [PIX_W-1:0]     frame_cnt,
    img_stream_gen_if.master     post
);

    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] HB_LAST   = CNT_W'(H_BLANK - 1);
    localparam logic [CNT_W-1:0] LEAD_LAST = CNT_W'(V_LEAD - 1);
    localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(V_TAIL - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;
    logic [PIX_W-1:0] fcnt_d;
    logic             frame_start;
    logic             vsync_d, hsync_d, valid_d, busy_d, done_d;

    // Next-state, counters and next-cycle outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        fcnt_d      = frame_cnt;
        frame_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    frame_start = 1'b1;
                end
            end
            ST_LEAD: begin
                if (cnt_q == LEAD_LAST) begin
                    state_d = ST_LINE;
                    x_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LINE: begin
                if (x_q == H_LAST) begin
                    state_d = ST_HBLANK;
                    cnt_d   = '0;
                end else begin
                    x_d = x_q + CNT_W'(1);
                end
            end
            ST_HBLANK: begin
                if (cnt_q == HB_LAST) begin
                    cnt_d = '0;
                    if (y_q == V_LAST) begin
                        state_d = ST_TAIL;
                    end else begin
                        state_d = ST_LINE;
                        x_d     = '0;
                        y_d     = y_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_TAIL: begin
                if (cnt_q == TAIL_LAST) begin
                    if (continuous) begin
                        frame_start = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (frame_start) begin
            state_d = ST_LEAD;
            cnt_d   = '0;
            y_d     = '0;
        end

        vsync_d = (state_d == ST_LEAD) || (state_d == ST_LINE) || (state_d == ST_HBLANK);
        hsync_d = (state_d == ST_LINE);
        valid_d = vsync_d & hsync_d;
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_TAIL) && (cnt_d == TAIL_LAST);
        if (done_d) begin
            fcnt_d = frame_cnt + PIX_W'(1);
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q             <= ST_IDLE;
            cnt_q               <= '0;
            x_q                 <= '0;
            y_q                 <= '0;
            frame_cnt           <= '0;
            busy                <= 1'b0;
            frame_done          <= 1'b0;
            post.post_img_vsync <= 1'b0;
            post.post_img_hsync <= 1'b0;
            post.post_img_valid <= 1'b0;
        end else begin
            state_q             <= state_d;
            cnt_q               <= cnt_d;
            x_q                 <= x_d;
            y_q                 <= y_d;
            frame_cnt           <= fcnt_d;
            busy                <= busy_d;
            frame_done          <= done_d;
            post.post_img_vsync <= vsync_d;
            post.post_img_hsync <= hsync_d;
            post.post_img_valid <= valid_d;
        end
    end

`ifdef IMG_STREAM_GEN_CHECKER_EN
    pattern_t pat_q, pat_d;

    // Pattern select is captured once per frame.
    always_comb begin
        pat_d = pat_q;
        if (frame_start) begin
            pat_d = pattern_t'(pattern_sel);
        end
    end

    // Latched pattern register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q <= PAT_RAMP;
        end else begin
            pat_q <= pat_d;
        end
    end
`else
    // Ramp-only build: pattern_sel has no effect.
    logic unused_pattern_sel;
    assign unused_pattern_sel = pattern_sel;
`endif

    img_pattern_calc u_pattern_calc (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_d   (valid_d),
        .x_lo      (x_d[PIX_W-1:0]),
        .y_lo      (y_d[PIX_W-1:0]),
        .frame_cnt (fcnt_d),
`ifdef IMG_STREAM_GEN_CHECKER_EN
        .pat       (pat_d),
`endif
        .data      (post.post_img_data)
    );

endmodule

// File: tb/tb_img_stream_gen.sv
// Directed bench for img_stream_gen (small 4x3 frame, plus a 16-wide line
// instance for the pattern-select check).
module tb_img_stream_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       continuous = 1'b0;
    logic       pattern_sel = 1'b0;
    logic       busy, frame_done;
    logic [7:0] frame_cnt;

    logic       start2 = 1'b0;
    logic       busy2, frame_done2;
    logic [7:0] frame_cnt2;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    img_stream_gen_if vif ();
    img_stream_gen_if vif2 ();

    img_stream_gen #(
        .H_ACTIVE(4), .V_ACTIVE(3), .H_BLANK(2), .V_LEAD(2), .V_TAIL(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
        .pattern_sel(pattern_sel), .busy(busy), .frame_done(frame_done),
        .frame_cnt(frame_cnt), .post(vif)
    );

    img_stream_gen #(
        .H_ACTIVE(16), .V_ACTIVE(1), .H_BLANK(1), .V_LEAD(1), .V_TAIL(1)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .continuous(1'b0),
        .pattern_sel(1'b1), .busy(busy2), .frame_done(frame_done2),
        .frame_cnt(frame_cnt2), .post(vif2)
    );

    always #5 clk = ~clk;

    // Expected data of a frame with frame_cnt=0, indexed by cycles after start.
    int unsigned exp_f0 [30] = '{0, 0, 0, 1, 2, 3, 0, 0, 1, 2, 3, 4, 0, 0, 2,
                                 3, 4, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " vsync"}, 32'(vif.post_img_vsync), 0);
        check({tag, " hsync"}, 32'(vif.post_img_hsync), 0);
        check({tag, " valid"}, 32'(vif.post_img_valid), 0);
        check({tag, " data"}, 32'(vif.post_img_data), 0);
        check({tag, " done"}, 32'(frame_done), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int unsigned vs_cnt, hs_cnt, hs_rise, va_cnt, done_cnt;
        logic prev_h;

        // Reset and idle behaviour.
        do_reset();
        check_quiet("rst");
        check("rst frame_cnt", 32'(frame_cnt), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_quiet("idle");
        end

        // Single frame, start re-asserted while busy.
        start = 1'b1;
        step();
        start = 1'b0;
        vs_cnt = 0; hs_cnt = 0; hs_rise = 0; va_cnt = 0; done_cnt = 0; prev_h = 1'b0;
        for (int k = 0; k < 30; k++) begin
            vs_cnt += 32'(vif.post_img_vsync);
            hs_cnt += 32'(vif.post_img_hsync);
            va_cnt += 32'(vif.post_img_valid);
            done_cnt += 32'(frame_done);
            if (vif.post_img_hsync && !prev_h) hs_rise++;
            prev_h = vif.post_img_hsync;
            check($sformatf("f0 data k%0d", k), 32'(vif.post_img_data), exp_f0[k]);
            check($sformatf("f0 valid k%0d", k), 32'(vif.post_img_valid),
                  32'(vif.post_img_vsync & vif.post_img_hsync));
            check($sformatf("f0 done k%0d", k), 32'(frame_done), (k == 22) ? 1 : 0);
            check($sformatf("f0 busy k%0d", k), 32'(busy), (k <= 22) ? 1 : 0);
            if (k == 22) check("f0 frame_cnt", 32'(frame_cnt), 1);
            start = (k >= 4 && k <= 9) ? 1'b1 : 1'b0;
            step();
        end
        start = 1'b0;
        check("f0 vsync cycles", vs_cnt, 20);
        check("f0 hsync pulses", hs_rise, 3);
        check("f0 hsync cycles", hs_cnt, 12);
        check("f0 valid cycles", va_cnt, 12);
        check("f0 single frame", done_cnt, 1);
        check("f0 frame_cnt end", 32'(frame_cnt), 1);

        // Three back-to-back frames.
        do_reset();
        continuous = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 70; k++) begin
            check($sformatf("cont busy k%0d", k), 32'(busy), (k <= 68) ? 1 : 0);
            check($sformatf("cont done k%0d", k), 32'(frame_done),
                  (k == 22 || k == 45 || k == 68) ? 1 : 0);
            if (k == 22) check("cont fcnt1", 32'(frame_cnt), 1);
            if (k == 45) check("cont fcnt2", 32'(frame_cnt), 2);
            if (k == 68) check("cont fcnt3", 32'(frame_cnt), 3);
            if (k == 23 || k == 46) check($sformatf("cont nogap vsync k%0d", k), 32'(vif.post_img_vsync), 1);
            if (k >= 25 && k <= 28) check($sformatf("cont f1 data k%0d", k), 32'(vif.post_img_data), 32'(k - 24));
            if (k >= 48 && k <= 51) check($sformatf("cont f2 data k%0d", k), 32'(vif.post_img_data), 32'(k - 46));
            if (k == 50) continuous = 1'b0;
            step();
        end

        // Reset asserted during line 2 (frame_cnt=3 at this point).
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 15; k++) step();
        check("mid line2 data", 32'(vif.post_img_data), 6);
        check("mid line2 valid", 32'(vif.post_img_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_quiet("async rst");
        check("async rst frame_cnt", 32'(frame_cnt), 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_quiet("post rst idle");
        end
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("post rst data k%0d", k), 32'(vif.post_img_data), exp_f0[k]);
            step();
        end

        // Pattern select on a 16-pixel line.
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        for (int k = 0; k < 18; k++) begin
            if (k >= 1 && k <= 16) begin
`ifdef IMG_STREAM_GEN_CHECKER_EN
                check($sformatf("pat x%0d", k - 1), 32'(vif2.post_img_data), (k - 1 < 8) ? 0 : 255);
`else
                check($sformatf("pat x%0d", k - 1), 32'(vif2.post_img_data), 32'(k - 1));
`endif
                check($sformatf("pat valid x%0d", k - 1), 32'(vif2.post_img_valid), 1);
            end else begin
                check($sformatf("pat blank k%0d", k), 32'(vif2.post_img_data), 0);
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
